// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - digit-serial unsigned/signed magnitude comparator with start/done handshake
// Optional build macro: SERIAL_CMP_SIGNED_EN adds the is_signed input for two's complement compares.
module serial_magnitude_comparator #(
    parameter int WIDTH      = 16,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_valid,
    output logic                                start_ready,
    input  logic [WIDTH-1:0]                    a,
    input  logic [WIDTH-1:0]                    b,
`ifdef SERIAL_CMP_SIGNED_EN
    input  logic                                is_signed,
`endif
    output logic                                done,
    output logic                                busy,
    output logic                                equal,
    output logic                                greater,
    output logic                                less,
    output logic [$clog2(WIDTH/DIGIT):0]        cmp_cycles
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = $clog2(NDIG) + 1;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              found_q, found_d;
    logic              dir_q, dir_d;
    logic              signed_q, signed_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              equal_q, equal_d;
    logic              greater_q, greater_d;
    logic              less_q, less_d;
    logic [CW-1:0]     cmp_cycles_q, cmp_cycles_d;

    logic [DIGIT-1:0]  slice_a, slice_b;
    logic              slice_diff, first_diff, sign_hit, finish;
    logic              found_n, dir_n;
    logic [CW-1:0]     cnt_n;
    logic              sign_in;

`ifdef SERIAL_CMP_SIGNED_EN
    assign sign_in = is_signed;
`else
    assign sign_in = 1'b0;
`endif

    // Current digit compare and the decision whether this RUN cycle is the last one
    always_comb begin
        slice_a    = a_q[idx_q*DIGIT +: DIGIT];
        slice_b    = b_q[idx_q*DIGIT +: DIGIT];
        slice_diff = (slice_a != slice_b);
        first_diff = slice_diff && !found_q;
        cnt_n      = cnt_q + CW'(1);
        // Differing sign bits settle a signed compare on the very first RUN cycle
        sign_hit   = signed_q && (cnt_q == '0) && (a_q[WIDTH-1] != b_q[WIDTH-1]);
        found_n    = found_q || slice_diff || sign_hit;
        if (sign_hit) begin
            dir_n = !a_q[WIDTH-1];
        end else if (first_diff) begin
            dir_n = (slice_a > slice_b);
        end else begin
            dir_n = dir_q;
        end
        finish = sign_hit || (first_diff && (EARLY_EXIT != 0)) || (idx_q == '0);
    end

    // Next-state and registered-output computation for the IDLE/RUN/DONE sequence
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        found_d      = found_q;
        dir_d        = dir_q;
        signed_d     = signed_q;
        ready_d      = ready_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        equal_d      = equal_q;
        greater_d    = greater_q;
        less_d       = less_q;
        cmp_cycles_d = cmp_cycles_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid && ready_q) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = sign_in;
                    idx_d    = IW'(NDIG - 1);
                    cnt_d    = '0;
                    found_d  = 1'b0;
                    dir_d    = 1'b0;
                    ready_d  = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d   = cnt_n;
                found_d = found_n;
                dir_d   = dir_n;
                if (finish) begin
                    equal_d      = !found_n;
                    greater_d    = found_n && dir_n;
                    less_d       = found_n && !dir_n;
                    cmp_cycles_d = cnt_n;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any compare in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            idx_q        <= '0;
            cnt_q        <= '0;
            found_q      <= 1'b0;
            dir_q        <= 1'b0;
            signed_q     <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            equal_q      <= 1'b0;
            greater_q    <= 1'b0;
            less_q       <= 1'b0;
            cmp_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            found_q      <= found_d;
            dir_q        <= dir_d;
            signed_q     <= signed_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            equal_q      <= equal_d;
            greater_q    <= greater_d;
            less_q       <= less_d;
            cmp_cycles_q <= cmp_cycles_d;
        end
    end

    assign start_ready = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign equal       = equal_q;
    assign greater     = greater_q;
    assign less        = less_q;
    assign cmp_cycles  = cmp_cycles_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - scoreboard bench for early-exit and full-length comparator builds
module tb_serial_magnitude_comparator;

    localparam int W  = 16;
    localparam int D  = 4;
    localparam int ND = W / D;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic [W-1:0]  op_a, op_b;
    logic          sgn;

    logic          rdy[2];
    logic          dn[2];
    logic          bsy[2];
    logic          eq[2];
    logic          gt[2];
    logic          lt[2];
    logic [2:0]    ccy[2];

    always #5 clk = ~clk;

    // Instance 0 exits early, instance 1 always runs all digits
    serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(1)) u_dut_ee (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[0]),
        .a(op_a), .b(op_b),
`ifdef SERIAL_CMP_SIGNED_EN
        .is_signed(sgn),
`endif
        .done(dn[0]), .busy(bsy[0]), .equal(eq[0]), .greater(gt[0]), .less(lt[0]),
        .cmp_cycles(ccy[0])
    );

    serial_magnitude_comparator #(.WIDTH(W), .DIGIT(D), .EARLY_EXIT(0)) u_dut_full (
        .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(rdy[1]),
        .a(op_a), .b(op_b),
`ifdef SERIAL_CMP_SIGNED_EN
        .is_signed(sgn),
`endif
        .done(dn[1]), .busy(bsy[1]), .equal(eq[1]), .greater(gt[1]), .less(lt[1]),
        .cmp_cycles(ccy[1])
    );

    typedef struct {
        logic eq;
        logic gt;
        logic lt;
        int   cycles;
        int   acc;
    } exp_t;

    exp_t        sbq0[$];
    exp_t        sbq1[$];
    logic [2:0]  last_f[2];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic ms, input bit ee, input int acc);
        exp_t e;
        int   k;
        logic [D-1:0] da, db;
        k = 0;
        for (int i = ND - 1; i >= 0; i--) begin
            da = ma[i*D +: D];
            db = mb[i*D +: D];
            if (k == 0 && da != db) k = ND - i;
        end
        e.eq = (ma == mb);
        if (ms) begin
            e.gt = ($signed(ma) > $signed(mb));
            e.lt = ($signed(ma) < $signed(mb));
        end else begin
            e.gt = (ma > mb);
            e.lt = (ma < mb);
        end
        if (ms && ma[W-1] != mb[W-1]) e.cycles = 1;
        else if (ee && k != 0)        e.cycles = k;
        else                          e.cycles = ND;
        e.acc = acc;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on accepted request, pop and compare on done, check handshake/hold in between
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                int   qs;
                exp_t e;
                qs = (i == 0) ? sbq0.size() : sbq1.size();
                check($sformatf("ready%0d", i), {31'b0, rdy[i]}, {31'b0, qs == 0});
                check($sformatf("busy%0d", i), {31'b0, bsy[i]}, {31'b0, (qs != 0) && !dn[i]});
                if (dn[i]) begin
                    if (qs == 0) begin
                        check($sformatf("spurious_done%0d", i), 32'd1, 32'd0);
                    end else begin
                        e = (i == 0) ? sbq0.pop_front() : sbq1.pop_front();
                        check($sformatf("flags%0d", i), {29'b0, eq[i], gt[i], lt[i]}, {29'b0, e.eq, e.gt, e.lt});
                        check($sformatf("cmp_cycles%0d", i), {29'b0, ccy[i]}, e.cycles);
                        check($sformatf("latency%0d", i), cyc - e.acc, e.cycles + 1);
                        last_f[i] = {e.eq, e.gt, e.lt};
                    end
                end else begin
                    check($sformatf("flags_hold%0d", i), {29'b0, eq[i], gt[i], lt[i]}, {29'b0, last_f[i]});
                end
                if (start_valid && rdy[i]) begin
                    if (i == 0) sbq0.push_back(model(op_a, op_b, sgn, 1'b1, cyc));
                    else        sbq1.push_back(model(op_a, op_b, sgn, 1'b0, cyc));
                end
            end
        end
    end

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("%s_ready%0d", tag, i), {31'b0, rdy[i]}, 32'd1);
            check($sformatf("%s_busy%0d", tag, i), {31'b0, bsy[i]}, 32'd0);
            check($sformatf("%s_done%0d", tag, i), {31'b0, dn[i]}, 32'd0);
            check($sformatf("%s_flags%0d", tag, i), {29'b0, eq[i], gt[i], lt[i]}, 32'd0);
            check($sformatf("%s_cycles%0d", tag, i), {29'b0, ccy[i]}, 32'd0);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        sbq0.delete();
        sbq1.delete();
        last_f[0] = 3'b000;
        last_f[1] = 3'b000;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(rdy[0] && rdy[1] && sbq0.size() == 0 && sbq1.size() == 0) && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 100) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic is);
        wait_idle();
        op_a = ia;
        op_b = ib;
        sgn  = is;
        start_valid = 1'b1;
        @(posedge clk); #2;
        start_valid = 1'b0;
        op_a = W'($urandom);
        op_b = W'($urandom);
        sgn  = 1'b0;
    endtask

    task automatic issue_hold(input logic [W-1:0] ia, input logic [W-1:0] ib);
        int n;
        issue(ia, ib, 1'b0);
        op_a = '0;
        op_b = '0;
        start_valid = 1'b1;
        n = 0;
        while (!(rdy[0] && rdy[1]) && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= 50) check("hold_timeout", 32'd0, 32'd1);
        @(posedge clk); #2;
        start_valid = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        start_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        sgn  = 1'b0;
        apply_reset();
        repeat (3) @(posedge clk);
        #2;
        check_reset("por");
        rst = 1'b0;

        issue(16'h1234, 16'h1234, 1'b0);
        wait_idle();
        @(posedge clk); #2;
        apply_reset();
        #1;
        check_reset("idle_rst");
        @(posedge clk); #2;
        rst = 1'b0;

        issue(16'h9000, 16'h8FFF, 1'b0);
        issue_hold(16'h1233, 16'h1234);

        issue(16'h1230, 16'h1234, 1'b0);
        @(posedge clk); #2;
        @(posedge clk); #2;
        apply_reset();
        #1;
        check_reset("run_rst");
        repeat (3) @(posedge clk);
        #1;
        check_reset("run_rst_hold");
        #1;
        rst = 1'b0;

        issue(16'h0001, 16'h0000, 1'b0);
`ifdef SERIAL_CMP_SIGNED_EN
        issue(16'hFFFF, 16'h0001, 1'b1);
        issue(16'hFFFF, 16'h0001, 1'b0);
        issue(16'h8000, 16'h8001, 1'b1);
        issue(16'h7FFF, 16'h7FF0, 1'b1);
`endif
        for (int t = 0; t < 24; t++) begin
            ra = W'($urandom);
            rb = ra;
            if (t % 3 != 0) rb[($urandom_range(0, ND - 1))*D +: D] = 4'($urandom);
            if (t % 5 == 0) rb = W'($urandom);
`ifdef SERIAL_CMP_SIGNED_EN
            issue(ra, rb, 1'($urandom));
`else
            issue(ra, rb, 1'b0);
`endif
        end
        wait_idle();
        check("drain0", sbq0.size(), 32'd0);
        check("drain1", sbq1.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
